imem_responder: RTL

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder.sv | 106 ++++++++++
 1 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder for an i-cache refill port.
// A request is accepted in IDLE, waits LATENCY cycles in WAIT and is answered
// with a single-cycle strobe in RESP. Storage is a word array preloaded through
// a separate write port. Misaligned or out-of-window addresses answer with
// o_err and a zero data word instead of a memory read.
module imem_responder #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 1024,
    parameter int              LATENCY   = 2,
    parameter logic [XLEN-1:0] BASE_ADDR = '0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_DataReq,
    input  logic [XLEN-1:0]          i_MemAddr,
    output logic [XLEN-1:0]          o_DataBlock,
    output logic                     o_MemReady,
    output logic                     o_err,
    input  logic                     i_ld_we,
    input  logic [$clog2(DEPTH)-1:0] i_ld_addr,
    input  logic [XLEN-1:0]          i_ld_data
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [3:0]      count;
    logic [XLEN-1:0] addr_latched;
    logic [XLEN-1:0] mem [DEPTH];

    logic [XLEN-1:0] word_idx;
    logic            misaligned;
    logic            out_of_range;
    logic            resp_err;

    // Word index relative to the window base; the subtraction wraps, so
    // addresses below the base land far above DEPTH and are flagged.
    assign word_idx     = (addr_latched - BASE_ADDR) >> 2;
    assign misaligned   = (addr_latched[1:0] != 2'b00);
    assign out_of_range = (word_idx >= XLEN'(DEPTH));
    assign resp_err     = misaligned | out_of_range;

    // Preload port: array is never reset, and writes are ignored during reset.
    always_ff @(posedge i_clk) begin
        if (i_ld_we && !i_rst) begin
            mem[i_ld_addr] <= i_ld_data;
        end
    end

    // Request FSM with registered response; the array read happens on the
    // final WAIT edge, so a same-edge preload write returns the old word.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            count        <= '0;
            addr_latched <= '0;
            o_DataBlock  <= '0;
            o_MemReady   <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_MemReady <= 1'b0;
                    o_err      <= 1'b0;
                    if (i_DataReq) begin
                        addr_latched <= i_MemAddr;
                        count        <= 4'(LATENCY - 1);
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    if (!i_DataReq) begin
                        // Requester withdrew: drop the transaction silently.
                        count <= '0;
                        state <= IDLE;
                    end else if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end else begin
                        o_DataBlock <= resp_err ? '0 : mem[word_idx[AW-1:0]];
                        o_err       <= resp_err;
                        o_MemReady  <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    o_MemReady <= 1'b0;
                    o_err      <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    o_MemReady <= 1'b0;
                    o_err      <= 1'b0;
                    count      <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
